ic_ram_rd: RTL and testbench



---
 rtl/ic_ram_rd_if.sv | 36 +++
 rtl/ic_ram_rd.sv | 143 ++++++++++++++
 tb/tb_ic_ram_rd.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ic_ram_rd_if.sv
// ic_ram_rd_if: port bundle for the ic_ram streaming read engine.
//   master : engine side (ic_ram_rd)
//   slave  : environment side (requester, ic_ram read port B, stream sink)
// Signals:
//   req_valid/req_ready/req_addr/req_len : request handshake (start address, word count)
//   addrb/doutb                          : ic_ram read port B (address out, data in)
//   m_valid/m_ready/m_data/m_last        : output word stream
//   busy/done/err                        : status (done/err are one-cycle pulses)
interface ic_ram_rd_if #(
  parameter int unsigned ram_dw = 128,
  parameter int unsigned ram_aw = 9
);
  logic              req_valid;
  logic              req_ready;
  logic [ram_aw-1:0] req_addr;
  logic [ram_aw:0]   req_len;
  logic [ram_aw-1:0] addrb;
  logic [ram_dw-1:0] doutb;
  logic              m_valid;
  logic              m_ready;
  logic [ram_dw-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  req_valid, req_addr, req_len, doutb, m_ready,
    output req_ready, addrb, m_valid, m_data, m_last, busy, done, err
  );

  modport slave (
    output req_valid, req_addr, req_len, doutb, m_ready,
    input  req_ready, addrb, m_valid, m_data, m_last, busy, done, err
  );
endinterface

// File: rtl/ic_ram_rd.sv
// ic_ram_rd: streaming read engine for ic_ram port B.
// Accepts a (start address, word count) request, issues reads on addrb, absorbs the
// one-cycle RAM latency with a 2-stage in-flight tracker and a 4-entry output FIFO,
// and presents words on a valid/ready stream with m_last on the final word.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : ic_ram_rd_if.master (request, RAM port B, output stream, busy/done/err)
// Optional feature: define IC_RD_WRAP_CHK_EN to reject requests whose address range
// runs past the top of the RAM (err + done pulse, no reads). Without it addresses wrap.
module ic_ram_rd #(
  parameter int unsigned ram_dw = 128,
  parameter int unsigned ram_aw = 9
) (
  input logic         clk,
  input logic         rst_n,
  ic_ram_rd_if.master bus
);

  localparam int unsigned dp = 1 << ram_aw;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [ram_aw-1:0] addr_q;       // next address to issue
  logic [ram_aw-1:0] addrb_q;
  logic [ram_aw:0]   issue_cnt_q;  // reads still to issue
  logic [ram_aw:0]   beat_cnt_q;   // beats still to hand over
  logic              fl_a_q;       // in-flight stage (a): address presented
  logic              fl_b_q;       // in-flight stage (b): RAM read pending, doutb valid
  logic [ram_dw-1:0] fifo_q [4];
  logic [1:0]        wptr_q;
  logic [1:0]        rptr_q;
  logic [2:0]        fcnt_q;
  logic              done_q;
  logic              err_q;

  logic       push;
  logic       pop;
  logic       m_valid;
  logic [2:0] pending;
  logic       can_issue;
  logic       wrap_bad;

`ifdef IC_RD_WRAP_CHK_EN
  logic [ram_aw+1:0] req_end;
  assign req_end  = (ram_aw+2)'(bus.req_addr) + (ram_aw+2)'(bus.req_len);
  assign wrap_bad = req_end > (ram_aw+2)'(dp);
`else
  assign wrap_bad = 1'b0;
`endif

  assign m_valid = fcnt_q != 3'd0;
  assign push    = fl_b_q;
  assign pop     = m_valid & bus.m_ready;

  // Reads are only issued when every word in the pipe is guaranteed a FIFO slot.
  assign pending   = fcnt_q + {2'b00, fl_a_q} + {2'b00, fl_b_q};
  assign can_issue = (state_q == StIssue) && (pending < 3'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      addrb_q     <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      fl_a_q      <= 1'b0;
      fl_b_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      fl_a_q <= 1'b0;
      fl_b_q <= fl_a_q;

      if (push) begin
        fifo_q[wptr_q] <= bus.doutb;
        wptr_q         <= wptr_q + 2'd1;
      end
      if (pop) begin
        rptr_q     <= rptr_q + 2'd1;
        beat_cnt_q <= beat_cnt_q - (ram_aw+1)'(1);
      end
      fcnt_q <= fcnt_q + {2'b00, push} - {2'b00, pop};

      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            if (bus.req_len == '0 || wrap_bad) begin
              done_q <= 1'b1;
              err_q  <= wrap_bad;
            end else begin
              // First read goes out on the acceptance edge itself.
              addrb_q     <= bus.req_addr;
              addr_q      <= bus.req_addr + ram_aw'(1);
              issue_cnt_q <= bus.req_len - (ram_aw+1)'(1);
              beat_cnt_q  <= bus.req_len;
              fl_a_q      <= 1'b1;
              state_q     <= (bus.req_len == (ram_aw+1)'(1)) ? StDrain : StIssue;
            end
          end
        end
        StIssue: begin
          if (can_issue) begin
            addrb_q     <= addr_q;
            addr_q      <= addr_q + ram_aw'(1);
            issue_cnt_q <= issue_cnt_q - (ram_aw+1)'(1);
            fl_a_q      <= 1'b1;
            if (issue_cnt_q == (ram_aw+1)'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Last handshake implies the pipe and FIFO are already empty.
          if (pop && beat_cnt_q == (ram_aw+1)'(1)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = state_q == StIdle;
  assign bus.busy      = state_q != StIdle;
  assign bus.addrb     = addrb_q;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = fifo_q[rptr_q];
  assign bus.m_last    = m_valid && (beat_cnt_q == (ram_aw+1)'(1));
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ic_ram_rd.sv
// tb_ic_ram_rd: self-checking bench for ic_ram_rd with a behavioural ic_ram model.
// Expected beats come from a queue built straight from the RAM contents and the
// request (addr, len), plus fixed timing expectations relative to acceptance.
module tb_ic_ram_rd;

  localparam int unsigned Dw = 128;
  localparam int unsigned Aw = 9;
  localparam int unsigned Dp = 1 << Aw;
`ifdef IC_RD_WRAP_CHK_EN
  localparam bit WrapChk = 1'b1;
`else
  localparam bit WrapChk = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   last_wait;

  logic [Dw-1:0] mem [Dp];

  ic_ram_rd_if #(.ram_dw(Dw), .ram_aw(Aw)) bus ();

  ic_ram_rd #(.ram_dw(Dw), .ram_aw(Aw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ic_ram port B: one-cycle read latency.
  initial bus.doutb = '0;
  always @(posedge clk) bus.doutb <= mem[bus.addrb];

  typedef struct {
    int    addr;
    int    len;
    int    mode;       // 0: m_ready=1, 1: random, 2: fixed toggle pattern
    bit    exp_err;
    int    exp_beats;
    string name;
  } vec_t;

  task automatic chk(input string name, input logic [Dw-1:0] act, input logic [Dw-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_req(input int addr, input int len, input int mode, input bit exp_err,
                         input int exp_beats, input string name);
    logic [Dw-1:0] q[$];
    logic [Dw-1:0] exp_d;
    logic [Dw-1:0] pdata;
    logic          plast;
    bit            stalled;
    bit            seen_valid;
    int            pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int            p;
    int            waited;
    int            idx;
    int            nbeats;
    int            first_idx;
    int            last_hs;
    int            done_idx;
    int            done_cnt;
    int            budget;
    logic          err_at_done;

    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_req_ready: got 0 want 1 after %0d cycles", name, waited);
      return;
    end

    // Reference: words addr..addr+len-1 modulo depth, none if rejected.
    if (!(WrapChk && (addr + len > int'(Dp)))) begin
      for (int i = 0; i < len; i++) q.push_back(mem[(addr + i) % Dp]);
    end

    bus.req_valid = 1'b1;
    bus.req_addr  = Aw'(addr);
    bus.req_len   = (Aw+1)'(len);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '1;
    bus.req_len   = '1;

    stalled = 0; seen_valid = 0; p = 0; idx = 0; nbeats = 0;
    first_idx = -1; last_hs = -1; done_idx = -1; done_cnt = 0;
    err_at_done = 1'b0; pdata = '0; plast = 1'b0;
    budget = 10 * len + 60;
    while (done_cnt == 0 && idx < budget) begin
      @(negedge clk);
      idx++;
      if (bus.m_valid) seen_valid = 1;
      if (mode == 0) bus.m_ready = 1'b1;
      else if (mode == 1) bus.m_ready = ($urandom_range(0, 9) < 7);
      else begin
        bus.m_ready = (seen_valid && p < 7) ? (pat[p] != 0) : 1'b1;
        if (seen_valid) p++;
      end
      if (stalled) begin
        checks++;
        if (!bus.m_valid || bus.m_data !== pdata || bus.m_last !== plast) begin
          failures++;
          $display("FAIL %s_stall: got v=%0b d=0x%0h l=%0b want v=1 d=0x%0h l=%0b",
                   name, bus.m_valid, bus.m_data, bus.m_last, pdata, plast);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_idx    = idx;
        err_at_done = bus.err;
      end
      if (bus.m_valid && bus.m_ready) begin
        nbeats++;
        if (first_idx < 0) first_idx = idx;
        last_hs = idx;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s_extra_beat: got 0x%0h want no beat", name, bus.m_data);
        end else begin
          exp_d = q.pop_front();
          chk({name, "_data"}, bus.m_data, exp_d);
          chk({name, "_last"}, Dw'(bus.m_last), Dw'(q.size() == 0));
        end
      end
      stalled = bus.m_valid && !bus.m_ready;
      pdata   = bus.m_data;
      plast   = bus.m_last;
    end

    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done in %0d cycles want done", name, budget);
      return;
    end
    chk({name, "_beats"}, Dw'(nbeats), Dw'(exp_beats));
    chk({name, "_done_idx"}, Dw'(done_idx), Dw'((exp_beats > 0) ? last_hs + 1 : 1));
    chk({name, "_err"}, Dw'(err_at_done), Dw'(exp_err));
    chk({name, "_busy_done"}, Dw'(bus.busy), '0);
    chk({name, "_ready_done"}, Dw'(bus.req_ready), Dw'(1));
    chk({name, "_mvalid_done"}, Dw'(bus.m_valid), '0);
    if (mode == 0 && exp_beats > 0) begin
      chk({name, "_first_idx"}, Dw'(first_idx), Dw'(3));
      chk({name, "_last_idx"}, Dw'(last_hs), Dw'(exp_beats + 2));
    end
  endtask

  vec_t vecs [6];

  initial begin
    checks = 0; failures = 0; last_wait = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.m_ready   = 1'b1;
    for (int i = 0; i < int'(Dp); i++) mem[i] = Dw'(32'hDEAD_0000 + i);
    for (int i = 0; i < 16; i++) mem[i] = Dw'(i + 1);
    mem[Dp-2] = Dw'(32'hA);
    mem[Dp-1] = Dw'(32'hB);

    vecs[0] = '{addr: 0, len: 16, mode: 0, exp_err: 0, exp_beats: 16, name: "seq16"};
    vecs[1] = '{addr: 3, len: 4, mode: 2, exp_err: 0, exp_beats: 4, name: "stall4"};
    vecs[2] = '{addr: Dp-2, len: 4, mode: 0, exp_err: WrapChk,
                exp_beats: WrapChk ? 0 : 4, name: "wrap"};
    vecs[3] = '{addr: 7, len: 0, mode: 0, exp_err: 0, exp_beats: 0, name: "len0"};
    vecs[4] = '{addr: Dp-1, len: 1, mode: 1, exp_err: 0, exp_beats: 1, name: "top1"};
    vecs[5] = '{addr: 0, len: Dp, mode: 0, exp_err: 0, exp_beats: Dp, name: "full"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", Dw'(bus.req_ready), Dw'(1));
    chk("rst_addrb", Dw'(bus.addrb), '0);
    chk("rst_m_valid", Dw'(bus.m_valid), '0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_m_last", Dw'(bus.m_last), '0);
    chk("rst_busy", Dw'(bus.busy), '0);
    chk("rst_done", Dw'(bus.done), '0);
    chk("rst_err", Dw'(bus.err), '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_req(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].exp_err,
              vecs[v].exp_beats, vecs[v].name);
    end

    // Reset in the middle of a stalled request.
    bus.m_ready   = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = '0;
    bus.req_len   = (Aw+1)'(16);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_m_valid_pre", Dw'(bus.m_valid), Dw'(1));
    chk("midrst_m_data_pre", bus.m_data, Dw'(1));
    chk("midrst_busy_pre", Dw'(bus.busy), Dw'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_m_valid", Dw'(bus.m_valid), '0);
    chk("midrst_busy", Dw'(bus.busy), '0);
    chk("midrst_req_ready", Dw'(bus.req_ready), Dw'(1));
    chk("midrst_done", Dw'(bus.done), '0);
    bus.m_ready = 1'b1;
    run_req(5, 1, 0, 1'b0, 1, "after_rst");

    // Back-to-back: second request accepted in the done cycle of the first.
    run_req(0, 2, 0, 1'b0, 2, "b2b_a");
    run_req(8, 2, 0, 1'b0, 2, "b2b_b");
    chk("b2b_accept_in_done", Dw'(last_wait), '0);

    // Random traffic against the reference queue.
    for (int i = 0; i < int'(Dp); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 25; t++) begin
      int  a;
      int  l;
      bit  bad;
      a   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, Dp - 1))
                                        : int'(Dp - 1 - $urandom_range(0, 15));
      l   = int'($urandom_range(0, 24));
      bad = WrapChk && (a + l > int'(Dp));
      run_req(a, l, 1, bad, bad ? 0 : l, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
